// File: rtl/sa_fifo_pkg.sv
// Shared constants and types for the 128x64 RAM-backed FIFO controller.
// Imported by the controller top and its output skid buffer.
package sa_fifo_pkg;

    localparam int FIFO_DEPTH = 128;
    localparam int FIFO_AW    = 7;
    localparam int FIFO_DW    = 64;
    localparam int FIFO_CW    = 8;

    typedef logic [FIFO_AW-1:0] ptr_t;
    typedef logic [FIFO_CW-1:0] cnt_t;
    typedef logic [1:0]         skid_cnt_t;

endpackage

// File: rtl/sa_fifo_ctrl_128x64_skid2.sv
// Two-entry output skid buffer: captures RAM read data, presents the
// oldest entry on a valid/ready stream. Head is always entry 0.
module sa_fifo_skid2
    import sa_fifo_pkg::*;
#(
    parameter int DW = FIFO_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cap_vld,
    input  logic [DW-1:0] cap_data,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_data,
    output skid_cnt_t     cnt
);

    logic [DW-1:0] head;
    logic [DW-1:0] tail;
    logic          pop;

    assign pop      = out_vld && out_rdy;
    assign out_vld  = (cnt != 2'd0);
    assign out_data = head;

    // Occupancy: capture and pop in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 2'd0;
        end else if (cap_vld && !pop) begin
            cnt <= cnt + 2'd1;
        end else if (!cap_vld && pop) begin
            cnt <= cnt - 2'd1;
        end
    end

    // Storage: on pop the tail (or an arriving word) slides into the head.
    always_ff @(posedge clk) begin
        if (pop) begin
            head <= (cnt == 2'd2) ? tail : cap_data;
            if (cap_vld) begin
                tail <= cap_data;
            end
        end else if (cap_vld) begin
            if (cnt == 2'd0) begin
                head <= cap_data;
            end else begin
                tail <= cap_data;
            end
        end
    end

endmodule

// File: rtl/sa_fifo_ctrl_128x64.sv
// Valid/ready FIFO controller driving a 128x64 two-port RAM with
// 1-cycle read latency; prefetches into a 2-entry skid buffer.
module sa_fifo_ctrl_128x64
    import sa_fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW,
    parameter int DW    = FIFO_DW,
    parameter int CW    = FIFO_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [CW-1:0] fifo_count,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    input  logic [DW-1:0] ram_dout,
    input  logic [31:0]   pwrbus_ram_pd,
    output logic [31:0]   ram_pwrbus_ram_pd
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] ram_cnt;
    logic          inflight;
    skid_cnt_t     skid_cnt;
    logic          push;
    logic          pop;
    logic [2:0]    held;

    // Accept only on registered occupancy so wr_prdy never sees rd_prdy.
    assign wr_prdy = !rst && (fifo_count < CW'(DEPTH));
    assign push    = wr_pvld && wr_prdy;
    assign pop     = rd_pvld && rd_prdy;

    // Words already committed to the output side after this cycle's pop.
    assign held   = {1'b0, skid_cnt} + {2'b0, inflight} - {2'b0, pop};
    assign ram_re = (ram_cnt != '0) && (held < 3'd2);
    assign ram_ra = rd_ptr;

    assign ram_we = push;
    assign ram_wa = wr_ptr;
    assign ram_di = wr_pd;

    assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

    // Pointers, occupancies and the read-in-flight flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_cnt    <= '0;
            fifo_count <= '0;
            inflight   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (ram_re) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            ram_cnt    <= ram_cnt + CW'(push) - CW'(ram_re);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            inflight   <= ram_re;
        end
    end

    sa_fifo_skid2 #(
        .DW(DW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .cap_vld (inflight),
        .cap_data(ram_dout),
        .out_vld (rd_pvld),
        .out_rdy (rd_prdy),
        .out_data(rd_pd),
        .cnt     (skid_cnt)
    );

endmodule
